// File: rtl/user_output_device.sv
// rtl/user_output_device.sv - Avalon-MM LED pattern queue with hold timer and drain interrupt
// Optional feature: define USER_OUTPUT_PWM_EN for CTRL[7:4] brightness dimming.
module user_output_device #(
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_CYCLES = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       avl_address,
    input  logic       avl_read,
    input  logic       avl_write,
    input  logic [7:0] avl_writedata,
    output logic [7:0] avl_readdata,
    output logic       avl_irq_n,
    output logic [7:0] leds
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] HOLD_INIT = CW'(HOLD_CYCLES - 1);
    localparam logic [3:0] DEPTH4 = 4'(FIFO_DEPTH);

    typedef enum logic {ST_IDLE, ST_SHOW} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   hold_q, hold_d;
    logic [7:0]      pattern_q, pattern_d;
    logic [7:0]      fifo_q [FIFO_DEPTH];
    logic [7:0]      fifo_d [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [3:0]      count_q, count_d;
    logic            irq_en_q, irq_en_d;
    logic            done_q, done_d;
    logic            overflow_q, overflow_d;

    logic            wr_data, wr_ctrl, push_ok, pop, set_done, busy;
    logic            unused_read;

    assign unused_read = avl_read;
    assign wr_data     = avl_write && !avl_address;
    assign wr_ctrl     = avl_write && avl_address;
    assign push_ok     = wr_data && (count_q < DEPTH4);
    assign busy        = (state_q == ST_SHOW);

    // Display sequencer: the hold counter reaching zero marks the last clock of a pattern.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        pattern_d = pattern_q;
        pop       = 1'b0;
        set_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (count_q != 4'd0) begin
                    pop       = 1'b1;
                    pattern_d = fifo_q[rd_ptr_q];
                    hold_d    = HOLD_INIT;
                    state_d   = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (hold_q != '0) begin
                    hold_d = hold_q - CW'(1);
                end else if (count_q != 4'd0) begin
                    pop       = 1'b1;
                    pattern_d = fifo_q[rd_ptr_q];
                    hold_d    = HOLD_INIT;
                end else begin
                    state_d  = ST_IDLE;
                    set_done = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q + {3'b000, push_ok} - {3'b000, pop};
        irq_en_d   = irq_en_q;
        done_d     = done_q;
        overflow_d = overflow_q;
        if (push_ok) begin
            fifo_d[wr_ptr_q] = avl_writedata;
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (wr_data && !push_ok) begin
            overflow_d = 1'b1;
        end
        if (wr_ctrl) begin
            irq_en_d = avl_writedata[0];
            if (avl_writedata[1]) overflow_d = 1'b0;
            if (avl_writedata[2]) done_d = 1'b0;
        end
        // Drain completion beats a CTRL clear; a fresh push means the queue is not drained.
        if (push_ok) begin
            done_d = 1'b0;
        end else if (set_done) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
        if (!reset) begin
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            pattern_q  <= 8'h00;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= 4'd0;
            irq_en_q   <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            pattern_q  <= pattern_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            irq_en_q   <= irq_en_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

    assign avl_readdata = avl_address ? pattern_q
                                      : {overflow_q, done_q, irq_en_q, busy, count_q};
    assign avl_irq_n    = ~(irq_en_q & done_q);

`ifdef USER_OUTPUT_PWM_EN
    logic [3:0] bright_q, bright_d, pwm_q, pwm_d;

    always_comb begin
        bright_d = bright_q;
        pwm_d    = pwm_q + 4'd1;
        if (wr_ctrl) bright_d = avl_writedata[7:4];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            bright_q <= 4'hF;
            pwm_q    <= 4'd0;
        end else begin
            bright_q <= bright_d;
            pwm_q    <= pwm_d;
        end
    end

    // Full brightness bypasses the comparator so 4'hF is steady-on rather than 15/16.
    assign leds = ((bright_q == 4'hF) || (pwm_q < bright_q)) ? pattern_q : 8'h00;
`else
    assign leds = pattern_q;
`endif
endmodule

// File: tb/tb_user_output_device.sv
// tb/tb_user_output_device.sv - directed self-checking bench for user_output_device
module tb_user_output_device;
    logic       clk = 1'b0;
    logic       reset;
    logic       avl_address, avl_read, avl_write;
    logic [7:0] avl_writedata, avl_readdata, leds;
    logic       avl_irq_n;
    int         total = 0;
    int         bad = 0;
    logic [7:0] rv;
    int         hi_cnt;

    always #5 clk = ~clk;

    user_output_device #(.FIFO_DEPTH(4), .HOLD_CYCLES(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .avl_address  (avl_address),
        .avl_read     (avl_read),
        .avl_write    (avl_write),
        .avl_writedata(avl_writedata),
        .avl_readdata (avl_readdata),
        .avl_irq_n    (avl_irq_n),
        .leds         (leds)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic a, input logic [7:0] d);
        avl_address   = a;
        avl_writedata = d;
        avl_write     = 1'b1;
        tick();
        avl_write     = 1'b0;
        avl_address   = 1'b0;
    endtask

    task automatic rd(input logic a, output logic [7:0] d);
        avl_address = a;
        avl_read    = 1'b1;
        #1;
        d           = avl_readdata;
        avl_read    = 1'b0;
        avl_address = 1'b0;
        #1;
    endtask

    task automatic check_status(input string tag, input logic [7:0] exp);
        logic [7:0] v;
        rd(1'b0, v);
        check(tag, v, exp);
    endtask

    initial begin
        reset = 1'b0; avl_address = 1'b0; avl_read = 1'b0;
        avl_write = 1'b0; avl_writedata = 8'h00;
        tick();
        tick();
        reset = 1'b1;
        check("rst_leds", leds, 8'h00);
        check("rst_irq", {7'b0, avl_irq_n}, 8'h01);
        check_status("rst_status", 8'h00);

        // single pattern
        wr(1'b1, 8'h01);
        wr(1'b0, 8'hA5);
        check("single_lat0", leds, 8'h00);
        check_status("single_cnt1", 8'h21);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("single_leds_e%0d", i), leds, 8'hA5);
            check($sformatf("single_irq_e%0d", i), {7'b0, avl_irq_n}, 8'h01);
            if (i == 1) begin
                check_status("single_busy", 8'h30);
                rd(1'b1, rv);
                check("single_rdpat", rv, 8'hA5);
            end
        end
        tick();
        check_status("single_done", 8'h60);
        check("single_irq_on", {7'b0, avl_irq_n}, 8'h00);
        check("single_hold", leds, 8'hA5);
        wr(1'b1, 8'h05);
        check("single_irq_clr", {7'b0, avl_irq_n}, 8'h01);
        check_status("single_st_clr", 8'h20);

        // back-to-back
        wr(1'b0, 8'h11);
        wr(1'b0, 8'h22);
        wr(1'b0, 8'h33);
        check("b2b_e2", leds, 8'h11);
        for (int k = 3; k <= 13; k++) begin
            tick();
            check($sformatf("b2b_leds_e%0d", k), leds,
                  (k < 5) ? 8'h11 : (k < 9) ? 8'h22 : 8'h33);
            check($sformatf("b2b_irq_e%0d", k), {7'b0, avl_irq_n},
                  (k == 13) ? 8'h00 : 8'h01);
        end
        check_status("b2b_done", 8'h60);
        wr(1'b1, 8'h00);
        check("mask_irq", {7'b0, avl_irq_n}, 8'h01);
        check_status("mask_status", 8'h40);
        wr(1'b1, 8'h05);
        check_status("b2b_clr", 8'h20);

        // overflow: six consecutive pushes, the sixth arrives while full
        for (int i = 0; i < 6; i++) wr(1'b0, 8'hB0 + 8'(i));
        check_status("ovf_status", 8'hB3);
        check("ovf_leds_e5", leds, 8'hB1);
        for (int k = 6; k <= 21; k++) begin
            tick();
            check($sformatf("ovf_leds_e%0d", k), leds,
                  (k < 9) ? 8'hB1 : (k < 13) ? 8'hB2 : (k < 17) ? 8'hB3 : 8'hB4);
        end
        check_status("ovf_end", 8'hE0);
        wr(1'b1, 8'h03);
        check_status("ovf_clr", 8'h60);
        wr(1'b1, 8'h05);
        check_status("ovf_done_clr", 8'h20);

        // reset mid-display with two queued
        wr(1'b0, 8'h77);
        wr(1'b0, 8'h88);
        wr(1'b0, 8'h99);
        check("mid_leds", leds, 8'h77);
        check_status("mid_status", 8'h32);
        reset = 1'b0;
        tick();
        check("mid_rst_leds", leds, 8'h00);
        check_status("mid_rst_status", 8'h00);
        check("mid_rst_irq", {7'b0, avl_irq_n}, 8'h01);
        reset = 1'b1;
        repeat (8) tick();
        check("post_rst_leds", leds, 8'h00);
        check_status("post_rst_status", 8'h00);
        wr(1'b0, 8'h5A);
        check_status("post_push", 8'h01);
        tick();
        check("post_leds", leds, 8'h5A);
        rd(1'b1, rv);
        check("post_rdpat", rv, 8'h5A);
        repeat (5) tick();

`ifdef USER_OUTPUT_PWM_EN
        wr(1'b1, 8'h41);
        hi_cnt = 0;
        wr(1'b0, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            wr(1'b0, 8'hFF);
            if (leds == 8'hFF) hi_cnt++;
        end
        for (int i = 0; i < 13; i++) begin
            tick();
            if (leds == 8'hFF) hi_cnt++;
        end
        check("pwm_hi_of16", 8'(hi_cnt), 8'd4);
        rd(1'b1, rv);
        check("pwm_rdpat", rv, 8'hFF);
        wr(1'b1, 8'hF1);
        hi_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (leds == 8'hFF) hi_cnt++;
        end
        check("pwm_full", 8'(hi_cnt), 8'd16);
`else
        wr(1'b1, 8'h41);
        wr(1'b0, 8'hFF);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("nopwm_e%0d", i), leds, 8'hFF);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
